// File: rtl/seed_host_ctrl.sv
// seed_host_ctrl: host-side initiator for the SEED128 core with one-entry result buffer and watchdog
module seed_host_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_fValid,
  output logic         o_fReady,
  input  logic [127:0] i_Key,
  input  logic [127:0] i_Data,
  input  logic         i_fDec,
  output logic         o_fValid,
  input  logic         i_fReady,
  output logic [127:0] o_Data,
  output logic         o_fErr,
  output logic [127:0] o_CoreText,
  output logic         o_CoreStart,
  output logic         o_CoreDec,
  input  logic [127:0] i_CoreText,
  input  logic         i_CoreDone
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] KEY   = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [127:0]     key_r, data_r;
  logic             dec_r;
  logic [CNT_W-1:0] wdog;
  logic             accept, expire, finish;

  // New requests only enter while idle with an empty buffer, so a result never overwrites one
  assign o_fReady    = (state == IDLE) && !o_fValid;
  assign accept      = i_fValid && o_fReady;
  assign expire      = wdog == CNT_W'(TIMEOUT - 1);
  assign finish      = (state == WAIT) && (i_CoreDone || expire);
  assign o_CoreStart = state == START;
  assign o_CoreText  = state == START ? data_r : state == KEY ? key_r : '0;
  assign o_CoreDec   = dec_r;

  // Next-state selection: START and KEY each last exactly one cycle
  always_comb begin
    state_nxt = state == IDLE  ? (accept ? START : IDLE) :
                state == START ? KEY :
                state == KEY   ? WAIT :
                finish         ? IDLE : WAIT;
  end

  // Sequencer state and captured request; later upstream changes are not observed
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state  <= IDLE;
      key_r  <= '0;
      data_r <= '0;
      dec_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        key_r  <= i_Key;
        data_r <= i_Data;
        dec_r  <= i_fDec;
      end
    end
  end

  // Watchdog: cleared while the key is presented, counts every WAIT cycle
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) wdog <= '0;
    else if (state == KEY) wdog <= '0;
    else if (state == WAIT) wdog <= wdog + CNT_W'(1);
  end

  // Result buffer: done beats expiry; held stable until downstream accepts
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_fValid <= 1'b0;
      o_fErr   <= 1'b0;
      o_Data   <= '0;
    end else if (finish) begin
      o_fValid <= 1'b1;
      o_fErr   <= !i_CoreDone;
      o_Data   <= i_CoreDone ? i_CoreText : '0;
    end else if (o_fValid && i_fReady) begin
      o_fValid <= 1'b0;
      o_fErr   <= 1'b0;
      o_Data   <= '0;
    end
  end
endmodule

// File: tb/tb_seed_host_ctrl.sv
// tb_seed_host_ctrl: self-checking bench with a behavioural stand-in for the SEED128 core
module tb_seed_host_ctrl;
  localparam logic [127:0] PT = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] CT = 128'h5EBAC6E0054E166819AFF1CC6D346CDB;
  localparam logic [127:0] A5 = {16{8'hA5}};

  logic         i_Clk = 0, i_Rst = 0, i_fValid = 0, i_fReady = 1, i_fDec = 0;
  logic [127:0] i_Key = '0, i_Data = '0;
  logic         i_CoreDone;
  logic [127:0] i_CoreText;
  logic         o_fReady, o_fValid, o_fErr, o_CoreStart, o_CoreDec;
  logic [127:0] o_Data, o_CoreText;
  int total = 0, bad = 0;
  int mode = 0;
  logic late_done = 0;
  logic busy, st_dec, stub_done;
  int cnt;
  logic [127:0] st_key, st_data;

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic         dec;
    logic [127:0] exp;
    int           lat;
  } vec_t;
  vec_t vt[5];

  seed_host_ctrl dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_fValid(i_fValid), .o_fReady(o_fReady),
    .i_Key(i_Key), .i_Data(i_Data), .i_fDec(i_fDec), .o_fValid(o_fValid),
    .i_fReady(i_fReady), .o_Data(o_Data), .o_fErr(o_fErr), .o_CoreText(o_CoreText),
    .o_CoreStart(o_CoreStart), .o_CoreDec(o_CoreDec), .i_CoreText(i_CoreText),
    .i_CoreDone(i_CoreDone)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic logic [127:0] core_fn(input logic [127:0] k, d, input logic dec);
    logic [127:0] x;
    if (!dec && k == '0 && d == PT) return CT;
    if (dec && k == '0 && d == CT) return PT;
    x = d ^ k;
    return dec ? {x[7:0], x[127:8]} : ({d[119:0], d[127:120]} ^ k);
  endfunction

  // Stand-in core: text with start, key next cycle, done 18 (enc) / 34 (dec) cycles after start
  always @(posedge i_Clk or negedge i_Rst)
    if (!i_Rst) begin
      busy <= 0; cnt <= 0; st_key <= '0; st_data <= '0; st_dec <= 0;
    end else if (o_CoreStart) begin
      busy <= 1; cnt <= 1; st_data <= o_CoreText; st_dec <= o_CoreDec;
    end else if (busy) begin
      cnt <= cnt + 1;
      if (cnt == 1) st_key <= o_CoreText;
      if (stub_done) busy <= 0;
    end

  assign stub_done  = busy && (mode == 0 ? cnt == (st_dec ? 34 : 18) : mode == 2 ? cnt == 65 : 1'b0);
  assign i_CoreDone = stub_done | late_done;
  assign i_CoreText = stub_done ? (mode == 2 ? A5 : core_fn(st_key, st_data, st_dec)) :
                      late_done ? '1 : '0;

  task automatic tick;
    @(posedge i_Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Handshake a request; returns in cycle 1 (first cycle after the accepting edge)
  task automatic issue(input logic [127:0] k, d, input logic dec);
    int w = 0;
    i_Key = k; i_Data = d; i_fDec = dec; i_fValid = 1;
    while (!o_fReady && w < 200) begin tick; w++; end
    chk("accept_wait", 128'(w < 200), 128'(1));
    tick;
    i_fValid = 0; i_Key = rnd128(); i_Data = rnd128(); i_fDec = ~dec;
  endtask

  // Core-side protocol for cycles 1..3; returns in cycle 3
  task automatic check_core(input logic [127:0] k, d, input logic dec);
    chk("c1_start", o_CoreStart, 1);
    chk("c1_text", o_CoreText, d);
    chk("c1_dec", o_CoreDec, dec);
    chk("c1_ready", o_fReady, 0);
    tick;
    chk("c2_start", o_CoreStart, 0);
    chk("c2_text", o_CoreText, k);
    chk("c2_dec", o_CoreDec, dec);
    tick;
    chk("c3_text", o_CoreText, 0);
    chk("c3_start", o_CoreStart, 0);
  endtask

  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!o_fValid && n < 200) begin tick; n++; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vt[0] = '{128'h0, PT, 1'b0, CT, 20};
    vt[1] = '{128'h0, CT, 1'b1, PT, 36};
    vt[2] = '{128'h1, 128'hDEADBEEF_00000000_CAFEF00D_12345678, 1'b0,
              core_fn(128'h1, 128'hDEADBEEF_00000000_CAFEF00D_12345678, 1'b0), 20};
    vt[3] = '{'1, 128'h0, 1'b1, core_fn('1, 128'h0, 1'b1), 36};
    vt[4] = '{128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, '1, 1'b0,
              core_fn(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, '1, 1'b0), 20};
    #1;
    chk("rst_valid", o_fValid, 0);
    chk("rst_data", o_Data, 0);
    chk("rst_err", o_fErr, 0);
    chk("rst_start", o_CoreStart, 0);
    chk("rst_text", o_CoreText, 0);
    chk("rst_dec", o_CoreDec, 0);
    tick; tick;
    i_Rst = 1;
    tick;
    chk("idle_ready", o_fReady, 1);

    for (int i = 0; i < 5; i++) begin
      i_fReady = 1;
      issue(vt[i].key, vt[i].data, vt[i].dec);
      check_core(vt[i].key, vt[i].data, vt[i].dec);
      wait_valid(3, n);
      chk($sformatf("vec%0d_lat", i), n, vt[i].lat);
      chk($sformatf("vec%0d_data", i), o_Data, vt[i].exp);
      chk($sformatf("vec%0d_err", i), o_fErr, 0);
      chk($sformatf("vec%0d_rdy", i), o_fReady, 0);
      tick;
      chk($sformatf("vec%0d_clr", i), o_fValid, 0);
      chk($sformatf("vec%0d_clrdata", i), o_Data, 0);
      chk($sformatf("vec%0d_rdy2", i), o_fReady, 1);
    end

    i_fReady = 0;
    issue(128'h0, PT, 1'b0);
    check_core(128'h0, PT, 1'b0);
    wait_valid(3, n);
    chk("bp_lat", n, 20);
    i_Key = '0; i_Data = PT; i_fDec = 0; i_fValid = 1;
    for (int c = 0; c < 50; c++) begin
      chk("bp_valid", o_fValid, 1);
      chk("bp_data", o_Data, CT);
      chk("bp_ready", o_fReady, 0);
      chk("bp_nostart", o_CoreStart, 0);
      tick;
    end
    i_fReady = 1;
    tick;
    chk("bp_cleared", o_fValid, 0);
    chk("bp_not_yet", o_CoreStart, 0);
    chk("bp_ready_up", o_fReady, 1);
    tick;
    i_fValid = 0;
    check_core(128'h0, PT, 1'b0);
    wait_valid(3, n);
    chk("bp2_lat", n, 20);
    chk("bp2_data", o_Data, CT);
    tick;

    mode = 1; i_fReady = 0;
    issue(128'h55, 128'h77, 1'b0);
    check_core(128'h55, 128'h77, 1'b0);
    wait_valid(3, n);
    chk("to_lat", n, 67);
    chk("to_err", o_fErr, 1);
    chk("to_data", o_Data, 0);
    late_done = 1; tick; late_done = 0;
    chk("to_late_data", o_Data, 0);
    chk("to_late_err", o_fErr, 1);
    i_fReady = 1; tick;
    chk("to_clr", o_fValid, 0);
    chk("to_clr_err", o_fErr, 0);
    late_done = 1; tick; late_done = 0; tick;
    chk("late_ignored", o_fValid, 0);
    chk("late_idle", o_fReady, 1);

    mode = 2;
    issue(128'h9, 128'h3, 1'b1);
    check_core(128'h9, 128'h3, 1'b1);
    wait_valid(3, n);
    chk("exp_lat", n, 67);
    chk("exp_data", o_Data, A5);
    chk("exp_err", o_fErr, 0);
    tick;

    mode = 0;
    issue(128'h42, 128'h24, 1'b1);
    check_core(128'h42, 128'h24, 1'b1);
    repeat (9) tick;
    #2 i_Rst = 0;
    #1;
    chk("ar_valid", o_fValid, 0);
    chk("ar_data", o_Data, 0);
    chk("ar_err", o_fErr, 0);
    chk("ar_start", o_CoreStart, 0);
    chk("ar_dec", o_CoreDec, 0);
    chk("ar_text", o_CoreText, 0);
    tick; tick;
    i_Rst = 1;
    tick;
    issue(128'h0, PT, 1'b0);
    check_core(128'h0, PT, 1'b0);
    wait_valid(3, n);
    chk("ar2_lat", n, 20);
    chk("ar2_data", o_Data, CT);
    tick;

    for (int r = 0; r < 20; r++) begin
      logic [127:0] k, d, e;
      logic dc;
      k = rnd128(); d = rnd128(); dc = 1'($urandom_range(0, 1));
      e = core_fn(k, d, dc);
      i_fReady = 0;
      repeat ($urandom_range(0, 3)) tick;
      issue(k, d, dc);
      check_core(k, d, dc);
      wait_valid(3, n);
      chk("rnd_lat", n, dc ? 36 : 20);
      chk("rnd_data", o_Data, e);
      chk("rnd_err", o_fErr, 0);
      for (int g = 0; g < 8 && o_fValid; g++) begin
        logic rr;
        rr = 1'($urandom_range(0, 1));
        i_fReady = rr;
        tick;
        chk("rnd_hold_valid", o_fValid, !rr);
        if (!rr) chk("rnd_hold_data", o_Data, e);
      end
      if (o_fValid) begin i_fReady = 1; tick; end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
